// File: rtl/hilo_muldiv_unit_if.sv
// rtl/hilo_muldiv_unit_if.sv - EX-stage HI/LO request and status bundle for hilo_muldiv_unit
interface hilo_muldiv_unit_if #(parameter int WIDTH = 32);
    logic             op_valid;
    logic [1:0]       HI_write;
    logic [1:0]       LO_write;
    logic [5:0]       funct;
    logic             mf_req;
    logic [WIDTH-1:0] rs_val;
    logic [WIDTH-1:0] rt_val;
    logic [WIDTH-1:0] hi;
    logic [WIDTH-1:0] lo;
    logic             busy;
    logic             stall;

    modport master (
        output op_valid, HI_write, LO_write, funct, mf_req, rs_val, rt_val,
        input  hi, lo, busy, stall
    );

    modport slave (
        input  op_valid, HI_write, LO_write, funct, mf_req, rs_val, rt_val,
        output hi, lo, busy, stall
    );
endinterface

// File: rtl/hilo_muldiv_unit.sv
// rtl/hilo_muldiv_unit.sv - HI/LO registers with iterative divide; HILO_MULT_ITER_EN selects iterative multiply
module hilo_muldiv_unit #(
    parameter int WIDTH = 32
) (
    input logic               clk,
    input logic               reset_n,
    hilo_muldiv_unit_if.slave bus
);
    localparam int CW = $clog2(WIDTH);
    localparam logic [5:0] F_MTHI  = 6'h11;
    localparam logic [5:0] F_MTLO  = 6'h13;
    localparam logic [5:0] F_MULT  = 6'h18;
    localparam logic [5:0] F_MULTU = 6'h19;
    localparam logic [5:0] F_DIV   = 6'h1A;
    localparam logic [5:0] F_DIVU  = 6'h1B;

`ifdef HILO_MULT_ITER_EN
    typedef enum logic [2:0] {IDLE, DIV_RUN, DIV_FIX, MUL_RUN, MUL_FIX} state_t;
`else
    typedef enum logic [1:0] {IDLE, DIV_RUN, DIV_FIX} state_t;
`endif

    state_t           state_q, state_d;
    logic [WIDTH-1:0] hi_q, hi_d, lo_q, lo_d;
    logic [CW-1:0]    cnt_q, cnt_d;
    logic [WIDTH-1:0] rem_q, rem_d;   // partial remainder (div) / upper product (mul)
    logic [WIDTH-1:0] quo_q, quo_d;   // dividend shifting into quotient / multiplier shifting out
    logic [WIDTH-1:0] dvsr_q, dvsr_d; // divisor (div) / multiplicand (mul)
    logic             q_neg_q, q_neg_d, r_neg_q, r_neg_d;

    logic             wr_strobe, accept, busy, is_signed;
    logic             rs_neg, rt_neg;
    logic [WIDTH-1:0] abs_rs, abs_rt;
    logic [WIDTH:0]   shifted, diff;

    assign wr_strobe = (bus.HI_write == 2'b11) || (bus.LO_write == 2'b11);
    assign busy      = (state_q != IDLE);
    assign accept    = bus.op_valid && !busy && wr_strobe;
    assign is_signed = (bus.funct == F_MULT) || (bus.funct == F_DIV);
    assign rs_neg    = bus.rs_val[WIDTH-1];
    assign rt_neg    = bus.rt_val[WIDTH-1];
    assign abs_rs    = (is_signed && rs_neg) ? -bus.rs_val : bus.rs_val;
    assign abs_rt    = (is_signed && rt_neg) ? -bus.rt_val : bus.rt_val;

    // Restoring divide step: bring in the next dividend bit and trial-subtract the divisor.
    assign shifted = {rem_q, quo_q[WIDTH-1]};
    assign diff    = shifted - {1'b0, dvsr_q};

`ifndef HILO_MULT_ITER_EN
    logic [2*WIDTH-1:0] prod_s, prod_u;
    // Sign-extending to the full product width lets one unsigned multiply serve MULT.
    assign prod_s = {{WIDTH{rs_neg}}, bus.rs_val} * {{WIDTH{rt_neg}}, bus.rt_val};
    assign prod_u = {{WIDTH{1'b0}}, bus.rs_val} * {{WIDTH{1'b0}}, bus.rt_val};
`endif

    assign bus.hi    = hi_q;
    assign bus.lo    = lo_q;
    assign bus.busy  = busy;
    assign bus.stall = busy && bus.op_valid && (bus.mf_req || wr_strobe);

    // Next-state and datapath update for the HI/LO file and iterative engine.
    always_comb begin
`ifdef HILO_MULT_ITER_EN
        logic [WIDTH:0] sum;
        sum = {1'b0, rem_q} + (quo_q[0] ? {1'b0, dvsr_q} : {(WIDTH+1){1'b0}});
`endif
        state_d = state_q;
        hi_d    = hi_q;
        lo_d    = lo_q;
        cnt_d   = cnt_q;
        rem_d   = rem_q;
        quo_d   = quo_q;
        dvsr_d  = dvsr_q;
        q_neg_d = q_neg_q;
        r_neg_d = r_neg_q;
        case (state_q)
            IDLE: begin
                if (accept) begin
                    case (bus.funct)
                        F_MTHI: hi_d = bus.rs_val;
                        F_MTLO: lo_d = bus.rs_val;
                        F_MULT, F_MULTU: begin
`ifdef HILO_MULT_ITER_EN
                            state_d = MUL_RUN;
                            cnt_d   = CW'(WIDTH - 1);
                            rem_d   = '0;
                            quo_d   = abs_rt;
                            dvsr_d  = abs_rs;
                            q_neg_d = is_signed && (rs_neg ^ rt_neg);
`else
                            {hi_d, lo_d} = is_signed ? prod_s : prod_u;
`endif
                        end
                        F_DIV, F_DIVU: begin
                            state_d = DIV_RUN;
                            cnt_d   = CW'(WIDTH - 1);
                            rem_d   = '0;
                            quo_d   = abs_rs;
                            dvsr_d  = abs_rt;
                            // A zero divisor leaves an all-ones quotient, so skip its sign fix;
                            // the remainder then restores to rs_val itself.
                            q_neg_d = is_signed && (rs_neg ^ rt_neg) && (bus.rt_val != '0);
                            r_neg_d = is_signed && rs_neg;
                        end
                        default: ;
                    endcase
                end
            end
            DIV_RUN: begin
                if (!diff[WIDTH]) begin
                    rem_d = diff[WIDTH-1:0];
                    quo_d = {quo_q[WIDTH-2:0], 1'b1};
                end else begin
                    rem_d = shifted[WIDTH-1:0];
                    quo_d = {quo_q[WIDTH-2:0], 1'b0};
                end
                cnt_d = cnt_q - 1'b1;
                if (cnt_q == '0) state_d = DIV_FIX;
            end
            DIV_FIX: begin
                lo_d    = q_neg_q ? -quo_q : quo_q;
                hi_d    = r_neg_q ? -rem_q : rem_q;
                state_d = IDLE;
            end
`ifdef HILO_MULT_ITER_EN
            MUL_RUN: begin
                {rem_d, quo_d} = {sum, quo_q[WIDTH-1:1]};
                cnt_d = cnt_q - 1'b1;
                if (cnt_q == '0) state_d = MUL_FIX;
            end
            MUL_FIX: begin
                {hi_d, lo_d} = q_neg_q ? -{rem_q, quo_q} : {rem_q, quo_q};
                state_d      = IDLE;
            end
`endif
            default: state_d = IDLE;
        endcase
    end

    // State and datapath registers; reset abandons any operation in flight.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state_q <= IDLE;
            hi_q    <= '0;
            lo_q    <= '0;
            cnt_q   <= '0;
            rem_q   <= '0;
            quo_q   <= '0;
            dvsr_q  <= '0;
            q_neg_q <= 1'b0;
            r_neg_q <= 1'b0;
        end else begin
            state_q <= state_d;
            hi_q    <= hi_d;
            lo_q    <= lo_d;
            cnt_q   <= cnt_d;
            rem_q   <= rem_d;
            quo_q   <= quo_d;
            dvsr_q  <= dvsr_d;
            q_neg_q <= q_neg_d;
            r_neg_q <= r_neg_d;
        end
    end
endmodule
